// File: rtl/key_seq_if.sv
// Push-button inputs and command pulse outputs for the hex counter front-end.
// The master side drives the raw keys; the slave side is the key sequencer.
interface key_seq_if;
  logic key_clr_n;
  logic key_inc_n;
  logic key_dec_n;
  logic clr_pulse;
  logic inc_pulse;
  logic dec_pulse;
  logic busy;

  modport master (
    output key_clr_n, key_inc_n, key_dec_n,
    input  clr_pulse, inc_pulse, dec_pulse, busy
  );

  modport slave (
    input  key_clr_n, key_inc_n, key_dec_n,
    output clr_pulse, inc_pulse, dec_pulse, busy
  );
endinterface

// File: rtl/key_seq_ctrl.sv
// Synchronises and debounces three push-buttons, arbitrates inc/dec with
// auto-repeat, and emits single-cycle clr/inc/dec commands for the counter.
module key_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  key_seq_if.slave  kif
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  localparam int K_CLR = 0;
  localparam int K_INC = 1;
  localparam int K_DEC = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INC = 1'b0,
    OWN_DEC = 1'b1
  } owner_e;

  logic [2:0]            raw_n;
  logic [2:0]            key_act;
  logic [2:0]            sync1_d, sync1_q;
  logic [2:0]            sync2_d, sync2_q;
  logic [2:0]            deb_d, deb_q;
  logic [2:0][DB_W-1:0]  db_cnt_d, db_cnt_q;
  logic                  clr_prev_d, clr_prev_q;
  state_e                state_d, state_q;
  owner_e                owner_d, owner_q;
  logic [TMR_W-1:0]      timer_d, timer_q;
  logic                  clr_pulse_d, clr_pulse_q;
  logic                  inc_pulse_d, inc_pulse_q;
  logic                  dec_pulse_d, dec_pulse_q;
  logic                  busy_d, busy_q;
  logic                  owner_held;

  assign raw_n   = {kif.key_dec_n, kif.key_inc_n, kif.key_clr_n};
  assign key_act = ~sync2_q;

  // Two-flop synchroniser (raw keys are active-low and asynchronous)
  always_comb begin
    sync1_d = raw_n;
    sync2_d = sync1_q;
  end

  // Per-key debounce: a level change is accepted only after it has persisted
  // for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int k = 0; k < 3; k++) begin
      if (key_act[k] == deb_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_LAST) begin
        deb_d[k]    = key_act[k];
        db_cnt_d[k] = '0;
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + 1'b1;
      end
    end
  end

  assign owner_held = (owner_q == OWN_DEC) ? deb_q[K_DEC] : deb_q[K_INC];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    inc_pulse_d = 1'b0;
    dec_pulse_d = 1'b0;
    clr_pulse_d = deb_q[K_CLR] & ~clr_prev_q;
    clr_prev_d  = deb_q[K_CLR];

    // A held clear overrides everything and parks the FSM
    if (deb_q[K_CLR]) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (deb_q[K_INC] ^ deb_q[K_DEC]) begin
            inc_pulse_d = deb_q[K_INC];
            dec_pulse_d = deb_q[K_DEC];
            owner_d     = deb_q[K_DEC] ? OWN_DEC : OWN_INC;
            timer_d     = '0;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!owner_held) begin
            state_d = S_IDLE;
          end else if (REPEAT_EN != 0) begin
            if (timer_q == DELAY_LAST) begin
              inc_pulse_d = (owner_q == OWN_INC);
              dec_pulse_d = (owner_q == OWN_DEC);
              timer_d     = '0;
              state_d     = S_REPEAT;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        S_REPEAT: begin
          if (!owner_held) begin
            state_d = S_IDLE;
          end else if (timer_q == PERIOD_LAST) begin
            inc_pulse_d = (owner_q == OWN_INC);
            dec_pulse_d = (owner_q == OWN_DEC);
            timer_d     = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 3'b111;
      sync2_q     <= 3'b111;
      deb_q       <= 3'b000;
      db_cnt_q    <= '0;
      clr_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      owner_q     <= OWN_INC;
      timer_q     <= '0;
      clr_pulse_q <= 1'b0;
      inc_pulse_q <= 1'b0;
      dec_pulse_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      db_cnt_q    <= db_cnt_d;
      clr_prev_q  <= clr_prev_d;
      state_q     <= state_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      clr_pulse_q <= clr_pulse_d;
      inc_pulse_q <= inc_pulse_d;
      dec_pulse_q <= dec_pulse_d;
      busy_q      <= busy_d;
    end
  end

  assign kif.clr_pulse = clr_pulse_q;
  assign kif.inc_pulse = inc_pulse_q;
  assign kif.dec_pulse = dec_pulse_q;
  assign kif.busy      = busy_q;

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Directed bench for key_seq_ctrl with short debounce/repeat parameters.
// Pulses are logged with the rising-edge index at which they were registered.
module tb_key_seq_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   multi_hot;
  int   inc_q[$];
  int   dec_q[$];
  int   clr_q[$];

  key_seq_if kif ();

  key_seq_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .REPEAT_EN      (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kif  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kif.inc_pulse === 1'b1) inc_q.push_back(cyc);
    if (kif.dec_pulse === 1'b1) dec_q.push_back(cyc);
    if (kif.clr_pulse === 1'b1) clr_q.push_back(cyc);
    if ((int'(kif.inc_pulse) + int'(kif.dec_pulse) + int'(kif.clr_pulse)) > 1)
      multi_hot <= multi_hot + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    inc_q.delete();
    dec_q.delete();
    clr_q.delete();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int f;
  int r;
  int c;
  int exp_rep[6] = '{7, 27, 35, 43, 51, 59};
  int exp_arb[5] = '{7, 27, 35, 43, 51};

  initial begin
    checks        = 0;
    errors        = 0;
    multi_hot     = 0;
    rst_n         = 1'b0;
    kif.key_clr_n = 1'b1;
    kif.key_inc_n = 1'b1;
    kif.key_dec_n = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clr",  int'(kif.clr_pulse), 0);
    check("rst_inc",  int'(kif.inc_pulse), 0);
    check("rst_dec",  int'(kif.dec_pulse), 0);
    check("rst_busy", int'(kif.busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single press: pulse 7 edges after the fall, busy until release+7
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    wait_until(f + 6);
    check("single_busy_pre", int'(kif.busy), 0);
    wait_until(f + 7);
    check("single_busy_on", int'(kif.busy), 1);
    wait_until(f + 10);
    kif.key_inc_n = 1'b1;
    wait_until(f + 16);
    check("single_busy_held", int'(kif.busy), 1);
    wait_until(f + 17);
    check("single_busy_off", int'(kif.busy), 0);
    wait_until(f + 25);
    check("single_inc_cnt", inc_q.size(), 1);
    check("single_inc_at",  q_at(inc_q, 0), f + 7);
    check("single_dec_cnt", dec_q.size(), 0);
    check("single_clr_cnt", clr_q.size(), 0);

    // Bounce rejection: two 3-cycle low glitches, then a steady press
    clear_logs();
    f = cyc;
    kif.key_dec_n = 1'b0; wait_until(f + 3);
    kif.key_dec_n = 1'b1; wait_until(f + 6);
    kif.key_dec_n = 1'b0; wait_until(f + 9);
    kif.key_dec_n = 1'b1; wait_until(f + 12);
    f = cyc;
    kif.key_dec_n = 1'b0;
    wait_until(f + 10);
    kif.key_dec_n = 1'b1;
    wait_until(f + 25);
    check("bounce_dec_cnt", dec_q.size(), 1);
    check("bounce_dec_at",  q_at(dec_q, 0), f + 7);
    check("bounce_inc_cnt", inc_q.size(), 0);

    // Auto-repeat: raw low for 60 cycles
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    wait_until(f + 60);
    kif.key_inc_n = 1'b1;
    wait_until(f + 80);
    check("rep_inc_cnt", inc_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rep_inc_at%0d", i), q_at(inc_q, i), f + exp_rep[i]);
    check("rep_busy_end", int'(kif.busy), 0);

    // Arbitration: simultaneous press is ignored until dec releases
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    kif.key_dec_n = 1'b0;
    wait_until(f + 10);
    check("arb_both_inc", inc_q.size(), 0);
    check("arb_both_dec", dec_q.size(), 0);
    check("arb_both_busy", int'(kif.busy), 0);
    r = cyc;
    kif.key_dec_n = 1'b1;
    wait_until(r + 9);
    kif.key_inc_n = 1'b1;
    wait_until(r + 20);
    check("arb_rel_inc_cnt", inc_q.size(), 1);
    check("arb_rel_inc_at",  q_at(inc_q, 0), r + 7);
    check("arb_rel_dec_cnt", dec_q.size(), 0);

    // Arbitration: dec pressed while inc owns REPEAT is ignored
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    wait_until(f + 30);
    kif.key_dec_n = 1'b0;
    wait_until(f + 45);
    kif.key_inc_n = 1'b1;
    kif.key_dec_n = 1'b1;
    wait_until(f + 60);
    check("own_inc_cnt", inc_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("own_inc_at%0d", i), q_at(inc_q, i), f + exp_arb[i]);
    check("own_dec_cnt", dec_q.size(), 0);

    // Clear priority during REPEAT, then re-fire after clear releases
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    wait_until(f + 30);
    c = cyc;
    kif.key_clr_n = 1'b0;
    wait_until(c + 6);
    check("clr_busy_before", int'(kif.busy), 1);
    wait_until(c + 7);
    check("clr_busy_after", int'(kif.busy), 0);
    check("clr_pulse_on",   int'(kif.clr_pulse), 1);
    wait_until(f + 45);
    kif.key_clr_n = 1'b1;
    wait_until(f + 53);
    kif.key_inc_n = 1'b1;
    wait_until(f + 65);
    check("clr_cnt",  clr_q.size(), 1);
    check("clr_at",   q_at(clr_q, 0), c + 7);
    check("clr_inc_cnt", inc_q.size(), 4);
    check("clr_inc_at2", q_at(inc_q, 2), f + 35);
    check("clr_inc_refire", q_at(inc_q, 3), f + 52);

    // Mid-cycle reset while busy, key held across release
    clear_logs();
    f = cyc;
    kif.key_inc_n = 1'b0;
    wait_until(f + 8);
    check("mid_busy_pre", int'(kif.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(kif.busy), 0);
    check("mid_rst_inc",  int'(kif.inc_pulse), 0);
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    wait_until(r + 8);
    kif.key_inc_n = 1'b1;
    wait_until(r + 20);
    // A key held through reset looks like a fresh fall just before the first edge
    check("mid_inc_cnt", inc_q.size(), 1);
    check("mid_inc_at",  q_at(inc_q, 0), r + 7);

    check("one_hot", multi_hot, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
